// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: major opcodes, immediate-format select and the canonical NOP.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_CUSTOM0  = 7'b0001011;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_R   = 3'b101,
    IMM_F   = 3'b110,
    IMM_RAW = 3'b111
  } imm_op_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_opdec.sv
// Combinational pre-decode of a major opcode into the immediate-format select.
module inst_opdec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output imm_op_e    imm_op_o
);

  always_comb begin
    imm_op_o = IMM_RAW;
    // Compressed / non-32-bit encodings are passed through untouched
    if (opcode_i[1:0] == 2'b11) begin
      case (opcode_i)
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_LOAD_FP: imm_op_o = IMM_I;
        OPC_STORE, OPC_STORE_FP:                     imm_op_o = IMM_S;
        OPC_BRANCH:                                  imm_op_o = IMM_B;
        OPC_LUI, OPC_AUIPC:                          imm_op_o = IMM_U;
        OPC_JAL:                                     imm_op_o = IMM_J;
        OPC_OP, OPC_OP_FP:                           imm_op_o = IMM_R;
        OPC_CUSTOM0:                                 imm_op_o = IMM_F;
        default:                                     imm_op_o = IMM_RAW;
      endcase
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode FWFT instruction queue; opcode pre-decode happens on push so the head select is ready immediately.
module inst_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [XLEN-1:0]            fetch_inst_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [XLEN-1:0]            dec_inst_o,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic [2:0]                 dec_imm_op_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  r_inst [DEPTH];
  logic [XLEN-1:0]  r_pc   [DEPTH];
  imm_op_e          r_imm  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic    w_full;
  logic    w_empty;
  logic    w_push;
  logic    w_pop;
  imm_op_e w_imm_op;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Ready is a pure function of occupancy, so a pop never frees a slot in the same cycle
  assign w_push  = fetch_valid_i & ~w_full;
  assign w_pop   = dec_ready_i & ~w_empty;

  inst_opdec u_opdec (
    .opcode_i (fetch_inst_i[6:0]),
    .imm_op_o (w_imm_op)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_inst[r_wr_ptr] <= fetch_inst_i;
      r_pc[r_wr_ptr]   <= fetch_pc_i;
      r_imm[r_wr_ptr]  <= w_imm_op;
    end
  end

  assign fetch_ready_o = ~w_full;
  assign dec_valid_o   = ~w_empty;
  assign count_o       = r_count;
  assign dec_inst_o    = w_empty ? XLEN'(NOP_INST) : r_inst[r_rd_ptr];
  assign dec_pc_o      = w_empty ? '0 : r_pc[r_rd_ptr];
  assign dec_imm_op_o  = w_empty ? 3'b000 : r_imm[r_rd_ptr];

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue with hand-computed expectations.
module tb_inst_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_inst_i;
  logic [31:0] fetch_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic [2:0]  dec_imm_op_o;
  logic [2:0]  count_o;

  int n_total = 0;
  int n_bad   = 0;

  inst_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_inst_i  (fetch_inst_i),
    .fetch_pc_i    (fetch_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_inst_o    (dec_inst_o),
    .dec_pc_o      (dec_pc_o),
    .dec_imm_op_o  (dec_imm_op_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    fetch_valid_i = 1'b1;
    fetch_inst_i  = inst;
    fetch_pc_i    = pc;
    tick();
    fetch_valid_i = 1'b0;
  endtask

  logic [31:0] fill_inst [4];
  logic [2:0]  fill_imm  [4];
  logic [31:0] dec_vec   [7];
  logic [2:0]  dec_exp   [7];

  initial begin
    fill_inst = '{32'h00112223, 32'hFE0008E3, 32'h123450B7, 32'h0080006F};
    fill_imm  = '{3'b001, 3'b010, 3'b011, 3'b100};
    dec_vec   = '{32'h0000FFFF, 32'h00000001, 32'h00B50533, 32'h0000000B,
                  32'h00000007, 32'h00000027, 32'h00000053};
    dec_exp   = '{3'b111, 3'b111, 3'b101, 3'b110, 3'b000, 3'b001, 3'b101};

    rst_ni = 1'b0; flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
    fetch_inst_i = '0; fetch_pc_i = '0;
    repeat (2) tick();
    check("rst_valid", dec_valid_o, 0);
    check("rst_ready", fetch_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_inst", dec_inst_o, 32'h00000013);
    check("rst_pc", dec_pc_o, 0);
    check("rst_imm", dec_imm_op_o, 0);
    rst_ni = 1'b1;
    tick();

    // Single push into empty queue
    push_one(32'h00500093, 32'h100);
    check("p1_valid", dec_valid_o, 1);
    check("p1_imm", dec_imm_op_o, 3'b000);
    check("p1_pc", dec_pc_o, 32'h100);
    check("p1_inst", dec_inst_o, 32'h00500093);
    check("p1_count", count_o, 1);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    check("p1_drain", count_o, 0);

    // Fill to full
    for (int k = 0; k < 4; k++) push_one(fill_inst[k], 32'h104 + 32'(4 * k));
    check("full_count", count_o, 4);
    check("full_ready", fetch_ready_o, 0);
    fetch_valid_i = 1'b1; fetch_inst_i = 32'h00000033; fetch_pc_i = 32'h999;
    dec_ready_i = 1'b1;
    #1;
    check("full_ready_nocomb", fetch_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      check("fill_imm", dec_imm_op_o, fill_imm[k]);
      check("fill_pc", dec_pc_o, 32'h104 + 32'(4 * k));
      tick();
      fetch_valid_i = 1'b0;
      if (k == 0) check("full_push_refused", count_o, 3);
    end
    check("fill_empty", count_o, 0);
    check("fill_empty_valid", dec_valid_o, 0);
    dec_ready_i = 1'b0;

    // Streaming at occupancy 2
    push_one(32'h00000013, 32'h0);
    push_one(32'h00000013, 32'h4);
    dec_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_valid_i = 1'b1; fetch_inst_i = 32'h00000013; fetch_pc_i = 32'(8 + 4 * i);
      #1;
      check("stream_pc", dec_pc_o, 32'(4 * i));
      check("stream_count", count_o, 2);
      tick();
    end
    fetch_valid_i = 1'b0;
    check("stream_tail0", dec_pc_o, 32'h28);
    tick();
    check("stream_tail1", dec_pc_o, 32'h2C);
    tick();
    check("stream_empty", count_o, 0);
    dec_ready_i = 1'b0;

    // Flush with simultaneous push and pop
    push_one(32'h00000013, 32'h200);
    push_one(32'h00000013, 32'h204);
    push_one(32'h00000013, 32'h208);
    check("pre_flush_count", count_o, 3);
    flush_i = 1'b1; fetch_valid_i = 1'b1; fetch_inst_i = 32'h0080006F; fetch_pc_i = 32'h20C;
    dec_ready_i = 1'b1;
    tick();
    flush_i = 1'b0; fetch_valid_i = 1'b0; dec_ready_i = 1'b0;
    check("flush_count", count_o, 0);
    check("flush_valid", dec_valid_o, 0);
    check("flush_inst", dec_inst_o, 32'h00000013);
    check("flush_pc", dec_pc_o, 0);
    tick();
    check("flush_absent", count_o, 0);
    push_one(32'h00112223, 32'h300);
    check("post_flush_pc", dec_pc_o, 32'h300);
    check("post_flush_imm", dec_imm_op_o, 3'b001);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;

    // Opcode map corners
    for (int k = 0; k < 7; k++) begin
      push_one(dec_vec[k], 32'(16 * k));
      check("opdec_imm", dec_imm_op_o, dec_exp[k]);
      dec_ready_i = 1'b1;
      tick();
      dec_ready_i = 1'b0;
    end
    check("opdec_empty_imm", dec_imm_op_o, 0);

    // Asynchronous reset mid-stream
    push_one(32'h00112223, 32'h400);
    push_one(32'h00112223, 32'h404);
    check("pre_rst_count", count_o, 2);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_count", count_o, 0);
    check("arst_valid", dec_valid_o, 0);
    check("arst_ready", fetch_ready_o, 1);
    check("arst_inst", dec_inst_o, 32'h00000013);
    check("arst_pc", dec_pc_o, 0);
    check("arst_imm", dec_imm_op_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("arst_hold", count_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
